// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, RZ-level to RM-bit group table and FSM state
// type for the irq_rz interrupt request unit.
package irq_pkg;

    localparam int NIRQ_DEF = 32;
    localparam int NRM_DEF  = 10;

    // Vector returned when an acknowledge finds no unmasked request
    localparam logic [4:0] VEC_SPUR = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } irq_state_e;

    // RM bit that enables RZ level k
    function automatic int grp(input int k);
        if (k < 2)       return 0;
        else if (k == 2) return 1;
        else if (k == 3) return 2;
        else if (k < 12) return 3 + ((k - 4) >> 1);
        else if (k < 20) return 7;
        else if (k < 28) return 8;
        else             return 9;
    endfunction

endpackage

// File: rtl/irq_prio.sv
// irq_prio: combinational lowest-index priority encoder over the pending
// vector; level 0 has the highest priority. any flags a non-empty input.
module irq_prio #(
    parameter int N = 32
) (
    input  logic [N-1:0] req,
    output logic [4:0]   idx,
    output logic         any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 5'(i);
        end
    end

endmodule

// File: rtl/irq_rz.sv
// irq_rz: interrupt request unit, responder side of the irq/przerw handshake.
// Holds the RZ request and RM mask registers, drives a registered irq, and on
// a rising ack returns the winning level (or the spurious vector) while
// clearing the granted RZ bit.
// Optional feature: define IRQ_SOFT_EN to let w_rz/rz_d load RZ directly.
module irq_rz
    import irq_pkg::*;
#(
    parameter int NIRQ = NIRQ_DEF,
    parameter int NRM  = NRM_DEF
) (
    input  logic            clk,
    input  logic            clm,
    input  logic [NIRQ-1:0] src,
    input  logic            w_rm,
    input  logic [NRM-1:0]  rm_d,
    input  logic            ack,
    input  logic            w_rz,
    input  logic [NIRQ-1:0] rz_d,
    output logic            irq,
    output logic [4:0]      vec,
    output logic            vld,
    output logic            spur,
    output logic [NIRQ-1:0] rz_q,
    output logic [NRM-1:0]  rm_q
);

    localparam int RMW = (NRM > 1) ? $clog2(NRM) : 1;

    // rz_d/rm_d are bus data ports, so the register next-values use _next
    logic [NIRQ-1:0] rz_next;
    logic [NRM-1:0]  rm_next;
    logic [NIRQ-1:0] en;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] clr;
    logic [4:0]      win;
    logic            pend_any;
    logic            ack_edge;

    irq_state_e      state_q, state_d;
    logic [4:0]      vec_q, vec_d;
    logic            vld_q, vld_d;
    logic            spur_q, spur_d;
    logic            irq_q, irq_d;
    logic            ack_q, ack_d;

    // Expand the RM group bits into a per-level enable
    always_comb begin
        en = '0;
        for (int k = 0; k < NIRQ; k++) begin
            en[k] = rm_q[RMW'(grp(k))];
        end
    end

    assign pend = rz_q & en;

    irq_prio #(.N(NIRQ)) u_prio (
        .req (pend),
        .idx (win),
        .any (pend_any)
    );

    // Handshake FSM next state: grant on a rising ack, hold until ack drops
    always_comb begin
        ack_edge = ack & ~ack_q;
        state_d  = state_q;
        vec_d    = vec_q;
        vld_d    = vld_q;
        spur_d   = spur_q;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (ack_edge) begin
                    vld_d   = 1'b1;
                    state_d = GRANT;
                    if (pend_any) begin
                        vec_d  = win;
                        spur_d = 1'b0;
                        clr    = NIRQ'(1) << win;
                    end else begin
                        vec_d  = VEC_SPUR;
                        spur_d = 1'b1;
                    end
                end
            end
            GRANT: state_d = HOLD;
            HOLD: begin
                if (!ack) begin
                    vld_d   = 1'b0;
                    spur_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RZ/RM next values; a source set always beats a grant clear
    always_comb begin
        rz_next = (rz_q & ~clr) | src;
`ifdef IRQ_SOFT_EN
        if (w_rz) rz_next = rz_d | src;
`endif
        rm_next = w_rm ? rm_d : rm_q;
        irq_d   = pend_any;
        ack_d   = ack;
    end

`ifndef IRQ_SOFT_EN
    logic unused_soft;
    assign unused_soft = w_rz ^ (^rz_d);
`endif

    // State registers; ack history keeps tracking during clm so a held ack
    // across reset release is not mistaken for a new edge
    always_ff @(posedge clk) begin
        ack_q <= ack_d;
        if (clm) begin
            state_q <= IDLE;
            vec_q   <= '0;
            vld_q   <= 1'b0;
            spur_q  <= 1'b0;
            irq_q   <= 1'b0;
            rz_q    <= '0;
            rm_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            spur_q  <= spur_d;
            irq_q   <= irq_d;
            rz_q    <= rz_next;
            rm_q    <= rm_next;
        end
    end

    assign irq  = irq_q;
    assign vec  = vec_q;
    assign vld  = vld_q;
    assign spur = spur_q;

endmodule

// File: tb/tb_irq_rz.sv
// tb_irq_rz: directed scenarios plus randomized traffic against a
// transaction-level reference model of the irq_rz request unit.
module tb_irq_rz;

    logic        clk = 1'b0;
    logic        clm, w_rm, ack, w_rz;
    logic [31:0] src, rz_d;
    logic [9:0]  rm_d;
    logic        irq, vld, spur;
    logic [4:0]  vec;
    logic [31:0] rz_q;
    logic [9:0]  rm_q;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_rz;
    logic [9:0]  m_rm;
    logic [4:0]  m_vec;
    logic        m_irq, m_vld, m_spur, m_busy, m_ackd;
    int          m_age;

    int grp_tab[32] = '{0,0,1,2,3,3,4,4,5,5,6,6,
                        7,7,7,7,7,7,7,7,
                        8,8,8,8,8,8,8,8,
                        9,9,9,9};

    irq_rz dut (
        .clk  (clk),
        .clm  (clm),
        .src  (src),
        .w_rm (w_rm),
        .rm_d (rm_d),
        .ack  (ack),
        .w_rz (w_rz),
        .rz_d (rz_d),
        .irq  (irq),
        .vec  (vec),
        .vld  (vld),
        .spur (spur),
        .rz_q (rz_q),
        .rm_q (rm_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the model: what the unit should look like after this edge
    task automatic model_step();
        logic [31:0] en, pend, clr;
        int w;
        if (clm) begin
            m_rz = 0; m_rm = 0; m_irq = 0; m_vec = 0; m_vld = 0; m_spur = 0;
            m_busy = 0; m_age = 0; m_ackd = ack;
            return;
        end
        en = 0;
        for (int k = 0; k < 32; k++) en[k] = m_rm[grp_tab[k]];
        pend = m_rz & en;
        clr  = 0;
        if (!m_busy) begin
            if (ack && !m_ackd) begin
                m_busy = 1; m_age = 0; m_vld = 1;
                if (pend != 0) begin
                    w = 0;
                    while (!pend[w]) w++;
                    m_vec = w[4:0]; clr[w] = 1'b1; m_spur = 0;
                end else begin
                    m_vec = 5'd31; m_spur = 1;
                end
            end
        end else begin
            if (m_age > 0 && !ack) begin
                m_busy = 0; m_vld = 0; m_spur = 0;
            end
            m_age++;
        end
`ifdef IRQ_SOFT_EN
        if (w_rz) m_rz = rz_d | src;
        else
`endif
        m_rz = (m_rz & ~clr) | src;
        if (w_rm) m_rm = rm_d;
        m_irq  = (pend != 0);
        m_ackd = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_irq",  irq,  m_irq);
        chk("m_vec",  vec,  m_vec);
        chk("m_vld",  vld,  m_vld);
        chk("m_spur", spur, m_spur);
        chk("m_rz",   rz_q, m_rz);
        chk("m_rm",   rm_q, m_rm);
    endtask

    task automatic do_clm();
        clm = 1'b1; src = '0;
        tick();
        clm = 1'b0;
    endtask

    initial begin
        clm = 1'b1; src = '1; w_rm = 0; rm_d = 0; ack = 0; w_rz = 0; rz_d = 0;
        m_rz = 0; m_rm = 0; m_vec = 0; m_irq = 0; m_vld = 0; m_spur = 0;
        m_busy = 0; m_ackd = 0; m_age = 0;

        // Reset with all sources asserted
        repeat (3) tick();
        chk("rst_rz", rz_q, 32'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_vld", vld, 1'b0);
        clm = 1'b0;
        tick();
        chk("rel_rz", rz_q, 32'hFFFF_FFFF);
        do_clm();

        // Masking: RM bit 0 does not cover level 5, RM bit 3 does
        w_rm = 1; rm_d = 10'h001; tick();
        w_rm = 0; src = 32'h20; tick();
        src = 0;
        chk("mask_rz5", rz_q[5], 1'b1);
        tick();
        chk("mask_irq0", irq, 1'b0);
        w_rm = 1; rm_d = 10'h008; tick();
        w_rm = 0; tick();
        chk("mask_irq1", irq, 1'b1);
        do_clm();

        // Priority: levels 3 and 17, two handshakes
        w_rm = 1; rm_d = '1; tick();
        w_rm = 0; src = 32'h0002_0008; tick();
        src = 0; tick();
        ack = 1; tick();
        chk("pri_vec3", vec, 5'd3);
        chk("pri_vld", vld, 1'b1);
        chk("pri_rz3", rz_q[3], 1'b0);
        chk("pri_rz17", rz_q[17], 1'b1);
        tick(); tick();
        ack = 0; tick();
        chk("pri_drop", vld, 1'b0);
        ack = 1; tick();
        chk("pri_vec17", vec, 5'd17);
        chk("pri_vld2", vld, 1'b1);
        tick();
        chk("pri_irq0", irq, 1'b0);
        ack = 0; tick(); tick();
        do_clm();

        // Spurious acknowledge with everything masked
        src = 32'h4; tick();
        src = 0; ack = 1; tick();
        chk("spur_vec", vec, 5'd31);
        chk("spur_flag", spur, 1'b1);
        chk("spur_vld", vld, 1'b1);
        chk("spur_rz", rz_q, 32'h4);
        ack = 0; tick(); tick(); tick();
        do_clm();

        // Source held high across its own grant
        w_rm = 1; rm_d = '1; src = 32'h8; tick();
        w_rm = 0; tick();
        ack = 1; tick();
        chk("svc_vec", vec, 5'd3);
        chk("svc_rz3", rz_q[3], 1'b1);
        tick();
        chk("svc_irq", irq, 1'b1);
        ack = 0; src = 0; tick(); tick(); tick();
        do_clm();

        // Reset during HOLD with ack kept high
        w_rm = 1; rm_d = '1; src = 32'h200; tick();
        w_rm = 0; src = 0; ack = 1; tick();
        chk("mid_vec9", vec, 5'd9);
        tick(); tick();
        clm = 1; tick();
        chk("mid_vld", vld, 1'b0);
        clm = 0; src = 32'h10; w_rm = 1; rm_d = '1; tick();
        src = 0; w_rm = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_nogrant", vld, 1'b0);
        end
        ack = 0; tick();
        ack = 1; tick();
        chk("mid_vld2", vld, 1'b1);
        chk("mid_vec4", vec, 5'd4);
        ack = 0; tick(); tick();
        do_clm();

        // Software RZ write
        w_rz = 1; rz_d = 32'h8000_0000; tick();
        w_rz = 0;
`ifdef IRQ_SOFT_EN
        chk("soft_rz", rz_q, 32'h8000_0000);
`else
        chk("soft_rz", rz_q, 32'h0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clm  = ($urandom_range(0, 299) == 0);
            src  = 0;
            if ($urandom_range(0, 3) == 0) src = 32'h1 << $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) src = src | (32'h1 << $urandom_range(0, 31));
            w_rm = ($urandom_range(0, 9) == 0);
            rm_d = 10'($urandom);
            w_rz = ($urandom_range(0, 19) == 0);
            rz_d = $urandom;
            if ($urandom_range(0, 2) == 0) ack = ~ack;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
